// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared state encoding, grant and D/C constants for the LCD SPI
//            arbiter and its serializer.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } lcd_state_t;

    localparam logic [1:0] GNT_NONE = 2'd3;
    localparam logic       DC_CMD   = 1'b0;
    localparam logic       DC_DATA  = 1'b1;

    // Fixed priority: channel 0 wins, GNT_NONE when nobody asks.
    function automatic logic [1:0] pick_lowest(input logic [2:0] req);
        if (req[0]) begin
            return 2'd0;
        end else if (req[1]) begin
            return 2'd1;
        end else if (req[2]) begin
            return 2'd2;
        end
        return GNT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_tx
// Purpose  : 8-bit MSB-first SCL/SDA serializer with post-word idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_tx
    import lcd_pkg::*;
#(
    parameter int HALF_DIV   = 1,
    parameter int GAP_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n_in,
    input  logic       load,
    input  logic [7:0] data,
    output logic       done,
    output logic       lcd_clk_out,
    output logic       lcd_data_out
);

    localparam logic [7:0]  c_div_last = 8'(HALF_DIV - 1);
    localparam logic [15:0] c_gap_last = 16'(GAP_CYCLES - 1);
    localparam bit          c_has_gap  = (GAP_CYCLES != 0);

    lcd_state_t  r_state, w_state_nxt;
    logic [7:0]  r_div,   w_div_nxt;
    logic [2:0]  r_bit,   w_bit_nxt;
    logic        r_high,  w_high_nxt;
    logic [15:0] r_gap,   w_gap_nxt;
    logic [7:0]  r_shreg, w_shreg_nxt;
    logic        r_scl,   w_scl_nxt;
    logic        r_sda,   w_sda_nxt;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_high  <= 1'b0;
            r_gap   <= '0;
            r_shreg <= '0;
            r_scl   <= 1'b0;
            r_sda   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_high  <= w_high_nxt;
            r_gap   <= w_gap_nxt;
            r_shreg <= w_shreg_nxt;
            r_scl   <= w_scl_nxt;
            r_sda   <= w_sda_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_high_nxt  = r_high;
        w_gap_nxt   = r_gap;
        w_shreg_nxt = r_shreg;
        w_scl_nxt   = r_scl;
        w_sda_nxt   = r_sda;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = data;
                    w_sda_nxt   = data[7];
                    w_scl_nxt   = 1'b0;
                    w_div_nxt   = '0;
                    w_bit_nxt   = 3'd7;
                    w_high_nxt  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (r_div == c_div_last) begin
                    w_div_nxt = '0;
                    if (!r_high) begin
                        w_high_nxt = 1'b1;
                        w_scl_nxt  = 1'b1;
                    end else begin
                        w_high_nxt = 1'b0;
                        w_scl_nxt  = 1'b0;
                        if (r_bit == 3'd0) begin
                            w_sda_nxt = 1'b0;
                            if (c_has_gap) begin
                                w_state_nxt = ST_GAP;
                                w_gap_nxt   = '0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                done        = 1'b1;
                            end
                        end else begin
                            // Next bit is already sitting at shreg[6].
                            w_bit_nxt   = r_bit - 3'd1;
                            w_sda_nxt   = r_shreg[6];
                            w_shreg_nxt = {r_shreg[6:0], 1'b0};
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_gap == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                    w_gap_nxt   = '0;
                    done        = 1'b1;
                end else begin
                    w_gap_nxt = r_gap + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign lcd_clk_out  = r_scl;
    assign lcd_data_out = r_sda;

endmodule
`default_nettype wire

// File: rtl/lcd_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lcd_spi_arbiter
// Purpose  : Three-channel fixed-priority, burst-locking arbiter feeding one
//            LCD SPI serializer.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_spi_arbiter
    import lcd_pkg::*;
#(
    parameter int HALF_DIV   = 1,
    parameter int GAP_CYCLES = 50
) (
    input  logic       clk,
    input  logic       rst_n_in,
    input  logic       req_0,
    input  logic [8:0] word_0,
    input  logic       last_0,
    output logic       ack_0,
    input  logic       req_1,
    input  logic [8:0] word_1,
    input  logic       last_1,
    output logic       ack_1,
    input  logic       req_2,
    input  logic [8:0] word_2,
    input  logic       last_2,
    output logic       ack_2,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       lcd_dc_out,
    output logic       lcd_clk_out,
    output logic       lcd_data_out
);

    logic [1:0] r_gnt;
    logic [2:0] r_ack;
    logic [7:0] r_word;
    logic       r_dc;
    logic       r_load;
    logic       r_wait;
    logic       r_armed;

    logic [1:0] w_sel;
    logic       w_sel_req;
    logic       w_sel_last;
    logic [8:0] w_sel_word;
    logic       w_capture;
    logic       w_tx_done;

    // A held lock pins the selection to its owner; otherwise fixed priority.
    assign w_sel = (r_gnt == GNT_NONE) ? pick_lowest({req_2, req_1, req_0}) : r_gnt;

    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_word = '0;
        case (w_sel)
            2'd0: begin
                w_sel_req  = req_0;
                w_sel_last = last_0;
                w_sel_word = word_0;
            end
            2'd1: begin
                w_sel_req  = req_1;
                w_sel_last = last_1;
                w_sel_word = word_1;
            end
            2'd2: begin
                w_sel_req  = req_2;
                w_sel_last = last_2;
                w_sel_word = word_2;
            end
            default: begin
                w_sel_req = 1'b0;
            end
        endcase
    end

    // r_armed keeps the first post-reset edge from capturing.
    assign w_capture = r_armed & ~r_wait & w_sel_req;

    always_ff @(posedge clk or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_armed <= 1'b0;
            r_wait  <= 1'b0;
            r_load  <= 1'b0;
            r_gnt   <= GNT_NONE;
            r_ack   <= '0;
            r_word  <= '0;
            r_dc    <= DC_CMD;
        end else begin
            r_armed <= 1'b1;
            r_ack   <= '0;
            r_load  <= 1'b0;
            if (w_tx_done) begin
                r_wait <= 1'b0;
            end
            if (w_capture) begin
                r_ack  <= 3'b001 << w_sel;
                r_word <= w_sel_word[7:0];
                r_dc   <= w_sel_word[8];
                r_load <= 1'b1;
                r_wait <= 1'b1;
                r_gnt  <= w_sel_last ? GNT_NONE : w_sel;
            end
        end
    end

    lcd_spi_tx #(
        .HALF_DIV   (HALF_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_tx (
        .clk          (clk),
        .rst_n_in     (rst_n_in),
        .load         (r_load),
        .data         (r_word),
        .done         (w_tx_done),
        .lcd_clk_out  (lcd_clk_out),
        .lcd_data_out (lcd_data_out)
    );

    assign ack_0      = r_ack[0];
    assign ack_1      = r_ack[1];
    assign ack_2      = r_ack[2];
    assign gnt        = r_gnt;
    assign busy       = r_wait;
    assign lcd_dc_out = r_dc;

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_spi_arbiter
// Purpose  : Randomized self-checking bench for lcd_spi_arbiter against a
//            burst-level arbitration and bitstream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_spi_arbiter;

    localparam int HALF_DIV   = 1;
    localparam int GAP_CYCLES = 4;
    localparam int PERIOD     = 16 * HALF_DIV + GAP_CYCLES + 2;

    logic       clk      = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       req_0, req_1, req_2;
    logic [8:0] word_0, word_1, word_2;
    logic       last_0, last_1, last_2;
    logic       ack_0, ack_1, ack_2;
    logic [1:0] gnt;
    logic       busy, lcd_dc_out, lcd_clk_out, lcd_data_out;

    always #5 clk = ~clk;

    lcd_spi_arbiter #(.HALF_DIV(HALF_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk(clk), .rst_n_in(rst_n_in),
        .req_0(req_0), .word_0(word_0), .last_0(last_0), .ack_0(ack_0),
        .req_1(req_1), .word_1(word_1), .last_1(last_1), .ack_1(ack_1),
        .req_2(req_2), .word_2(word_2), .last_2(last_2), .ack_2(ack_2),
        .gnt(gnt), .busy(busy), .lcd_dc_out(lcd_dc_out),
        .lcd_clk_out(lcd_clk_out), .lcd_data_out(lcd_data_out)
    );

    // Pending words per requester, {last, dc, payload}.
    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    // Observed and expected logs: 13-bit {ch, word, gnt-after} per ack, and serial bits.
    logic [511:0] obs_log, exp_log, obs_bits, exp_bits, obs_dc, exp_dc;
    int obs_acks, exp_acks, obs_nbits, exp_nbits;
    int cyc, last_ack_cyc, min_sp, max_sp;
    logic prev_scl;
    int n_vec = 0;
    int n_err = 0;

    task automatic clear_logs();
        obs_log = '0; exp_log = '0; obs_bits = '0; exp_bits = '0; obs_dc = '0; exp_dc = '0;
        obs_acks = 0; exp_acks = 0; obs_nbits = 0; exp_nbits = 0;
        last_ack_cyc = -1; min_sp = 1000000; max_sp = 0;
    endtask

    task automatic drive_inputs();
        req_0  = (q0.size() > 0);
        word_0 = req_0 ? q0[0][8:0] : 9'h0;
        last_0 = req_0 ? q0[0][9] : 1'b0;
        req_1  = (q1.size() > 0);
        word_1 = req_1 ? q1[0][8:0] : 9'h0;
        last_1 = req_1 ? q1[0][9] : 1'b0;
        req_2  = (q2.size() > 0);
        word_2 = req_2 ? q2[0][8:0] : 9'h0;
        last_2 = req_2 ? q2[0][9] : 1'b0;
    endtask

    task automatic log_ack(input int ch);
        logic [9:0] head;
        head = 10'h3FF;
        case (ch)
            0: if (q0.size() > 0) head = q0.pop_front();
            1: if (q1.size() > 0) head = q1.pop_front();
            default: if (q2.size() > 0) head = q2.pop_front();
        endcase
        obs_log = {obs_log[498:0], 2'(ch), head[8:0], gnt};
        obs_acks++;
        if (last_ack_cyc >= 0) begin
            if (cyc - last_ack_cyc < min_sp) min_sp = cyc - last_ack_cyc;
            if (cyc - last_ack_cyc > max_sp) max_sp = cyc - last_ack_cyc;
        end
        last_ack_cyc = cyc;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (rst_n_in) begin
            if (ack_0) log_ack(0);
            if (ack_1) log_ack(1);
            if (ack_2) log_ack(2);
            if (!prev_scl && lcd_clk_out) begin
                obs_bits = {obs_bits[510:0], lcd_data_out};
                obs_dc   = {obs_dc[510:0], lcd_dc_out};
                obs_nbits++;
            end
        end
        prev_scl = lcd_clk_out;
        drive_inputs();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((q0.size() + q1.size() + q2.size() != 0 || busy) && k < budget);
        n_vec++;
        if (q0.size() + q1.size() + q2.size() != 0 || busy) begin
            n_err++;
            $display("FAIL %s timeout: %0d words still pending, busy=%0b, required 0 pending and idle within %0d cycles",
                     name, q0.size() + q1.size() + q2.size(), busy, budget);
        end
    endtask

    // Reference: one captured word, its bits MSB first, and the grant the lock rule leaves behind.
    function automatic void model_push(input int ch, input logic [8:0] w, input logic last);
        exp_log = {exp_log[498:0], 2'(ch), w, (last ? 2'd3 : 2'(ch))};
        exp_acks++;
        for (int b = 7; b >= 0; b--) begin
            exp_bits = {exp_bits[510:0], w[b]};
            exp_dc   = {exp_dc[510:0], w[8]};
            exp_nbits++;
        end
    endfunction

    // Whole bursts, lowest-numbered non-empty requester first, all requests present from the start.
    function automatic void build_expected();
        logic [9:0] m0[$];
        logic [9:0] m1[$];
        logic [9:0] m2[$];
        logic [9:0] h;
        int ch, left;
        bit open_burst;
        m0 = q0; m1 = q1; m2 = q2;
        while (m0.size() + m1.size() + m2.size() > 0) begin
            ch = (m0.size() > 0) ? 0 : ((m1.size() > 0) ? 1 : 2);
            open_burst = 1'b1;
            while (open_burst) begin
                case (ch)
                    0: h = m0.pop_front();
                    1: h = m1.pop_front();
                    default: h = m2.pop_front();
                endcase
                model_push(ch, h[8:0], h[9]);
                left = (ch == 0) ? m0.size() : ((ch == 1) ? m1.size() : m2.size());
                open_burst = !h[9] && (left > 0);
            end
        end
    endfunction

    task automatic test_reset();
        clear_logs();
        repeat (3) step();
        n_vec++;
        if ({ack_0, ack_1, ack_2} !== 3'b000 || gnt !== 2'd3 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset ctrl: acks=%b gnt=%0d busy=%b, required 000 3 0", {ack_0, ack_1, ack_2}, gnt, busy);
        end
        n_vec++;
        if ({lcd_clk_out, lcd_data_out, lcd_dc_out} !== 3'b000) begin
            n_err++;
            $display("FAIL reset pins: scl/sda/dc=%b, required 000", {lcd_clk_out, lcd_data_out, lcd_dc_out});
        end
        rst_n_in = 1'b1;
        repeat (5) step();
        n_vec++;
        if (obs_acks !== 0 || gnt !== 2'd3 || busy !== 1'b0 || obs_nbits !== 0) begin
            n_err++;
            $display("FAIL idle quiet: acks=%0d gnt=%0d busy=%b edges=%0d, required 0 3 0 0", obs_acks, gnt, busy, obs_nbits);
        end
    endtask

    task automatic test_single_word();
        clear_logs();
        q1.push_back({1'b1, 9'h02A});
        q1.push_back({1'b1, 9'($urandom)});
        build_expected();
        run_until_idle(200, "single");
        n_vec++;
        if (obs_bits[15:8] !== 8'h2A || obs_dc[15:8] !== 8'h00) begin
            n_err++;
            $display("FAIL single sda: bits=%h dc=%h, required 2a 00", obs_bits[15:8], obs_dc[15:8]);
        end
        n_vec++;
        if (obs_log !== exp_log || obs_acks !== exp_acks) begin
            n_err++;
            $display("FAIL single acks: got %0d log %h, required %0d log %h", obs_acks, obs_log[25:0], exp_acks, exp_log[25:0]);
        end
        n_vec++;
        if (obs_bits !== exp_bits || obs_nbits !== exp_nbits) begin
            n_err++;
            $display("FAIL single stream: got %0d bits %h, required %0d bits %h", obs_nbits, obs_bits[15:0], exp_nbits, exp_bits[15:0]);
        end
        n_vec++;
        if (min_sp !== PERIOD || max_sp !== PERIOD) begin
            n_err++;
            $display("FAIL single spacing: got %0d..%0d, required %0d", min_sp, max_sp, PERIOD);
        end
        n_vec++;
        if (gnt !== 2'd3 || lcd_clk_out !== 1'b0) begin
            n_err++;
            $display("FAIL single end: gnt=%0d scl=%b, required 3 0", gnt, lcd_clk_out);
        end
    endtask

    task automatic test_priority();
        clear_logs();
        q0.push_back({1'b0, 9'($urandom)});
        q0.push_back({1'b0, 9'($urandom)});
        q0.push_back({1'b1, 9'($urandom)});
        q1.push_back({1'b1, 9'($urandom)});
        q2.push_back({1'b1, 9'($urandom)});
        build_expected();
        run_until_idle(400, "priority");
        n_vec++;
        if (obs_log !== exp_log || obs_acks !== exp_acks) begin
            n_err++;
            $display("FAIL priority order: got %0d log %h, required %0d log %h", obs_acks, obs_log[64:0], exp_acks, exp_log[64:0]);
        end
        n_vec++;
        if (obs_bits !== exp_bits || obs_dc !== exp_dc || obs_nbits !== exp_nbits) begin
            n_err++;
            $display("FAIL priority stream: got %0d bits %h, required %0d bits %h", obs_nbits, obs_bits[39:0], exp_nbits, exp_bits[39:0]);
        end
        n_vec++;
        if (min_sp !== PERIOD || max_sp !== PERIOD) begin
            n_err++;
            $display("FAIL priority spacing: got %0d..%0d, required %0d", min_sp, max_sp, PERIOD);
        end
    endtask

    task automatic test_lock_stall();
        logic [8:0] w1, w2, w0;
        int k;
        clear_logs();
        w1 = 9'($urandom); w2 = 9'($urandom); w0 = 9'($urandom);
        q2.push_back({1'b0, w1});
        k = 0;
        while (obs_acks < 1 && k < 50) begin
            step();
            k++;
        end
        q0.push_back({1'b1, w0});
        repeat (80) step();
        n_vec++;
        if (obs_acks !== 1 || gnt !== 2'd2 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stall hold: acks=%0d gnt=%0d busy=%b, required 1 2 0", obs_acks, gnt, busy);
        end
        q2.push_back({1'b1, w2});
        model_push(2, w1, 1'b0);
        model_push(2, w2, 1'b1);
        model_push(0, w0, 1'b1);
        run_until_idle(300, "stall");
        n_vec++;
        if (obs_log !== exp_log || obs_acks !== exp_acks) begin
            n_err++;
            $display("FAIL stall order: got %0d log %h, required %0d log %h", obs_acks, obs_log[38:0], exp_acks, exp_log[38:0]);
        end
        n_vec++;
        if (obs_bits !== exp_bits || obs_dc !== exp_dc || obs_nbits !== exp_nbits) begin
            n_err++;
            $display("FAIL stall stream: got %0d bits %h, required %0d bits %h", obs_nbits, obs_bits[23:0], exp_nbits, exp_bits[23:0]);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [8:0] w;
        int k;
        clear_logs();
        q0.push_back({1'b0, 9'($urandom)});
        k = 0;
        while (obs_nbits < 3 && k < 60) begin
            step();
            k++;
        end
        #1 rst_n_in = 1'b0;
        #1;
        n_vec++;
        if ({lcd_clk_out, lcd_data_out, lcd_dc_out, busy, ack_0, ack_1, ack_2} !== 7'b0 || gnt !== 2'd3 || obs_nbits !== 3) begin
            n_err++;
            $display("FAIL midreset async: scl/sda/dc/busy/acks=%b gnt=%0d edges=%0d, required 0000000 3 3",
                     {lcd_clk_out, lcd_data_out, lcd_dc_out, busy, ack_0, ack_1, ack_2}, gnt, obs_nbits);
        end
        q0.delete();
        drive_inputs();
        repeat (3) step();
        clear_logs();
        w = 9'($urandom);
        q1.push_back({1'b1, w});
        drive_inputs();
        rst_n_in = 1'b1;
        k = 0;
        while (obs_acks < 1 && k < 20) begin
            step();
            k++;
        end
        n_vec++;
        if (k < 2 || obs_acks !== 1) begin
            n_err++;
            $display("FAIL release capture: ack after %0d edges (acks=%0d), required at least 2 edges and 1 ack", k, obs_acks);
        end
        model_push(1, w, 1'b1);
        run_until_idle(200, "midreset");
        n_vec++;
        if (obs_log !== exp_log || obs_bits !== exp_bits || obs_dc !== exp_dc || obs_nbits !== exp_nbits) begin
            n_err++;
            $display("FAIL midreset resend: log %h bits %h (%0d), required log %h bits %h (%0d)",
                     obs_log[12:0], obs_bits[7:0], obs_nbits, exp_log[12:0], exp_bits[7:0], exp_nbits);
        end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        for (int i = 0; i < 4; i++) q1.push_back({(i == 3), 1'b1, 8'($urandom)});
        build_expected();
        run_until_idle(400, "b2b");
        n_vec++;
        if (min_sp !== PERIOD || max_sp !== PERIOD || obs_acks !== 4) begin
            n_err++;
            $display("FAIL b2b spacing: %0d acks at %0d..%0d, required 4 at %0d", obs_acks, min_sp, max_sp, PERIOD);
        end
        n_vec++;
        if (obs_nbits !== 32 || obs_dc[31:0] !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL b2b dc: %0d edges dc %h, required 32 edges dc ffffffff", obs_nbits, obs_dc[31:0]);
        end
        n_vec++;
        if (obs_log !== exp_log || obs_bits !== exp_bits) begin
            n_err++;
            $display("FAIL b2b stream: log %h bits %h, required log %h bits %h", obs_log[51:0], obs_bits[31:0], exp_log[51:0], exp_bits[31:0]);
        end
    endtask

    task automatic test_random_bursts();
        int nb, len;
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            for (int ch = 0; ch < 3; ch++) begin
                nb = $urandom_range(0, 2);
                for (int b = 0; b < nb; b++) begin
                    len = $urandom_range(1, 3);
                    for (int j = 0; j < len; j++) begin
                        case (ch)
                            0: q0.push_back({(j == len - 1), 9'($urandom)});
                            1: q1.push_back({(j == len - 1), 9'($urandom)});
                            default: q2.push_back({(j == len - 1), 9'($urandom)});
                        endcase
                    end
                end
            end
            if (q0.size() + q1.size() + q2.size() == 0) q2.push_back({1'b1, 9'($urandom)});
            build_expected();
            run_until_idle(1000, "random");
            n_vec++;
            if (obs_log !== exp_log || obs_acks !== exp_acks) begin
                n_err++;
                $display("FAIL random[%0d] order: got %0d acks, required %0d; low log %h vs %h",
                         it, obs_acks, exp_acks, obs_log[63:0], exp_log[63:0]);
            end
            n_vec++;
            if (obs_bits !== exp_bits || obs_dc !== exp_dc || obs_nbits !== exp_nbits) begin
                n_err++;
                $display("FAIL random[%0d] stream: got %0d bits %h, required %0d bits %h",
                         it, obs_nbits, obs_bits[63:0], exp_nbits, exp_bits[63:0]);
            end
            if (exp_acks > 1) begin
                n_vec++;
                if (min_sp !== PERIOD || max_sp !== PERIOD) begin
                    n_err++;
                    $display("FAIL random[%0d] spacing: got %0d..%0d, required %0d", it, min_sp, max_sp, PERIOD);
                end
            end
        end
    endtask

    initial begin
        cyc = 0;
        prev_scl = 1'b0;
        rst_n_in = 1'b0;
        drive_inputs();
        test_reset();
        test_single_word();
        test_priority();
        test_lock_stall();
        test_reset_mid_word();
        test_back_to_back();
        test_random_bursts();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/lcd_spi_arbiter.md
LCD_SPI_ARBITER -- requirements
Module: lcd_spi_arbiter

Interface
REQ-001 The block SHALL have parameter HALF_DIV, default 1: system clocks per SCL half-period, legal range 1..255.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 50: idle clocks after each word, legal range 0..65535.
REQ-003 The block SHALL have the ports below; three channels n=0,1,2; ports named with suffix n (req_n, word_n, last_n, ack_n) exist once per channel.
- clk  in  1  system clock; single clock domain.
- rst_n_in  in  1  reset, asynchronous assert, active-low.
- req_n  in  1  channel n has a word pending.
- word_n  in  9  bit8 = D/C (0 command, 1 data); bits7:0 = payload.
- last_n  in  1  word_n is the final word of its burst.
- ack_n  out  1  one-cycle pulse when word_n is captured.
- gnt  out  2  owning channel (0..2); 3 = none.
- busy  out  1  high outside IDLE.
- lcd_dc_out  out  1  LCD D/C line.
- lcd_clk_out  out  1  SCL, idles low.
- lcd_data_out  out  1  SDA, MSB first.

Function
REQ-004 The FSM SHALL use states IDLE, SHIFT and GAP.
REQ-005 In IDLE with gnt=3, the block SHALL grant the lowest-numbered channel with req high, using fixed priority ch0 > ch1 > ch2.
REQ-006 A grant SHALL lock gnt to the granted channel until a word with last=1 from that channel is captured, then return gnt to 3.
REQ-007 While gnt is locked, the block SHALL ignore other channels' req; if the owner drops req, the block SHALL wait in IDLE without timeout.
REQ-008 Capture SHALL occur on the clock edge after IDLE sees the owner's req high (or any req when unlocked); on that edge the block SHALL:
- pulse ack_n for one cycle;
- register word_n;
- drive lcd_dc_out to word_n bit8;
- enter SHIFT.
REQ-009 For each bit, MSB first, SHIFT SHALL:
- drive lcd_clk_out low with lcd_data_out = bit for HALF_DIV clocks;
- then drive lcd_clk_out high for HALF_DIV clocks.
REQ-010 After bit0's high phase, the block SHALL drive lcd_clk_out low and enter GAP for GAP_CYCLES clocks, then return to IDLE.
REQ-011 Word period SHALL be 16*HALF_DIV + GAP_CYCLES + 2 clocks between consecutive acks under continuous req.
REQ-012 lcd_dc_out SHALL stay stable from capture until the next capture.
REQ-013 A requester SHALL hold word_n and last_n stable while req_n is high and ack_n is low; the next word SHALL be presented the cycle after ack_n.
REQ-014 If req deasserts after the grant decision but before ack, the block SHALL still capture and send the word; req SHALL be treated as a level, not a strobe.
REQ-015 A single-word burst (last=1 on the first word) SHALL lock for that word only.
REQ-016 Simultaneous req on all channels SHALL grant ch0; ch1 SHALL be served after ch0's last word, then ch2.
REQ-017 The gap counter SHALL be 16 bits; the bit counter SHALL be 3 bits; the divider SHALL be 8 bits; none SHALL wrap visibly outside its state.

Reset
REQ-018 While rst_n_in is low, the block SHALL hold, asynchronously:
- state = IDLE; gnt = 3;
- ack_n = 0; busy = 0;
- lcd_clk_out = 0; lcd_data_out = 0; lcd_dc_out = 0;
- all counters = 0.
REQ-019 Reset asserted mid-word SHALL abort the word with no completing SCL edge and discard the burst lock.
REQ-020 The first capture after reset release SHALL be no earlier than the second rising clk edge.

Structure
REQ-021 A shared package lcd_pkg SHALL hold:
- the state encoding;
- GNT_NONE = 2'd3;
- DC_CMD = 1'b0 and DC_DATA = 1'b1.
REQ-022 The serializer (SHIFT/GAP timing, pins) SHALL be sub-module lcd_spi_tx with a load/done handshake; lcd_spi_arbiter SHALL contain grant, lock and ack logic only.

Verification (HALF_DIV=1, GAP_CYCLES=4)
REQ-023 Single word: ch1 req, word 9'h02A, last=1 -> one ack_1; dc=0; SDA samples on SCL rising edges = 0,0,1,0,1,0,1,0; gnt returns to 3; next ack no earlier than 22 clocks later.
REQ-024 Priority: ch0, ch1 and ch2 request together; ch0 sends a 3-word burst (last on word 3) -> 3 acks on ch0, then ch1, then ch2; no interleaving.
REQ-025 Lock stall: ch2 owns the lock, drops req after word 1 (last=0), and ch0 requests -> no ack_0; ch2 reasserts req with last=1 -> ch2 completes, then ch0 is granted.
REQ-026 Reset mid-word: assert rst_n_in low after 3 SCL rising edges -> all outputs at reset values within the same cycle; after release, a new word transmits fully and correctly.
REQ-027 Back-to-back data: ch1 streams 4 words with bit8 = 1 -> ack spacing exactly 22 clocks; dc high throughout; exactly 32 SCL rising edges.
